display_arbiter: RTL

Controller that decides, cycle by cycle, which requester owns the six-digit lock display: the operational FSM or the setup FSM. It drives the `enable_o` / `enable_s` capture strobes of `display`, which latches `bcd_packet_operational` or `bcd_packet_setup` on those strobes. It also freezes timed operational messages (e.g. "open", "error") for a fixed hold time and forces an exit from setup after an inactivity timeout.

---
 rtl/display_arbiter.sv | 106 ++++++++++
 1 files changed

// File: rtl/display_arbiter.sv
// display_arbiter: decides whether the operational or setup FSM drives the display,
// freezing timed operational messages and forcing setup exit on inactivity.
module display_arbiter #(
    parameter int HOLD_CYCLES    = 50_000_000,
    parameter int TIMEOUT_CYCLES = 250_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_o,
    input  logic       msg_o,
    input  logic       req_s,
    input  logic       act_s,
    output logic       enable_o,
    output logic       enable_s,
    output logic [1:0] owner,
    output logic       hold_busy,
    output logic       setup_timeout
);
    localparam int MAX_CYCLES = HOLD_CYCLES > TIMEOUT_CYCLES ? HOLD_CYCLES : TIMEOUT_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES);
    localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] TO_LD   = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE = 2'b00, OPER = 2'b01, SETUP = 2'b10, HOLD = 2'b11} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          lockout_q, lockout_d;
    logic          msg_acc, timeout;

    assign msg_acc       = msg_o & (state_q != SETUP);
    assign enable_o      = ~rst & ((state_q == OPER) | msg_acc);
    assign enable_s      = state_q == SETUP;
    assign owner         = state_q;
    assign hold_busy     = state_q == HOLD;
    assign setup_timeout = timeout;

    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        lockout_d = req_s ? lockout_q : 1'b0;
        timeout   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_s && !lockout_q) begin
                    state_d = SETUP;
                    cnt_d   = TO_LD;
                end else if (msg_acc) begin
                    state_d = HOLD;
                    cnt_d   = HOLD_LD;
                end else if (req_o) begin
                    state_d = OPER;
                end
            end
            OPER: begin
                if (req_s) begin
                    state_d = SETUP;
                    cnt_d   = TO_LD;
                end else if (msg_acc) begin
                    state_d = HOLD;
                    cnt_d   = HOLD_LD;
                end else if (!req_o) begin
                    state_d = IDLE;
                end
            end
            HOLD: begin
                if (msg_acc) begin
                    cnt_d = HOLD_LD;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (req_s && !lockout_q) begin
                    state_d = SETUP;
                    cnt_d   = TO_LD;
                end else begin
                    state_d = req_o ? OPER : IDLE;
                end
            end
            SETUP: begin
                // Losing the request wins over a simultaneous timeout.
                if (!req_s) begin
                    state_d = req_o ? OPER : IDLE;
                end else if (act_s) begin
                    cnt_d = TO_LD;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    state_d   = IDLE;
                    timeout   = 1'b1;
                    lockout_d = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            lockout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            lockout_q <= lockout_d;
        end
    end
endmodule
